// File: rtl/instruction_loader.sv
// Boot loader: assembles a big-endian word stream from UART bytes into instruction
// memory, then hands the memory address port to the fetch stage and releases the CPU.
module instruction_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WORDS  = 16000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_run,
  output logic                  load_error,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [31:0]           MAX_W = 32'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

  state_t                state_r, state_nxt;
  logic [1:0]            byte_cnt_r, byte_cnt_nxt;
  logic [7:0]            hdr_hi_r, hdr_hi_nxt;
  logic [ADDR_WIDTH-1:0] len_r, len_nxt;
  logic [31:0]           asm_r, asm_nxt;
  logic                  we_nxt;
  logic [31:0]           wdata_nxt;
  logic [ADDR_WIDTH-1:0] wl_nxt, wl_inc;
  logic                  run_nxt, err_nxt;
  logic [15:0]           hdr_len;

  assign hdr_len     = {hdr_hi_r, rx_data};
  assign wl_inc      = words_loaded + ONE;
  assign mem_address = cpu_run ? fetch_address : words_loaded;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= S_LEN;
      byte_cnt_r       <= 2'd0;
      hdr_hi_r         <= 8'd0;
      len_r            <= '0;
      asm_r            <= 32'd0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= 32'd0;
      words_loaded     <= '0;
      cpu_run          <= 1'b0;
      load_error       <= 1'b0;
    end else begin
      state_r          <= state_nxt;
      byte_cnt_r       <= byte_cnt_nxt;
      hdr_hi_r         <= hdr_hi_nxt;
      len_r            <= len_nxt;
      asm_r            <= asm_nxt;
      mem_write_enable <= we_nxt;
      mem_write_data   <= wdata_nxt;
      words_loaded     <= wl_nxt;
      cpu_run          <= run_nxt;
      load_error       <= err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state_r;
    byte_cnt_nxt = byte_cnt_r;
    hdr_hi_nxt   = hdr_hi_r;
    len_nxt      = len_r;
    asm_nxt      = asm_r;
    we_nxt       = 1'b0;
    wdata_nxt    = mem_write_data;
    wl_nxt       = words_loaded;
    run_nxt      = cpu_run;
    err_nxt      = load_error;
    case (state_r)
      S_LEN: begin
        if (rx_valid) begin
          if (byte_cnt_r == 2'd0) begin
            hdr_hi_nxt   = rx_data;
            byte_cnt_nxt = 2'd1;
          end else begin
            byte_cnt_nxt = 2'd0;
            len_nxt      = ADDR_WIDTH'(hdr_len);
            if (hdr_len == 16'd0) begin
              state_nxt = S_RUN;
              run_nxt   = 1'b1;
            end else if ({16'd0, hdr_len} > MAX_W) begin
              state_nxt = S_ERR;
              err_nxt   = 1'b1;
            end else begin
              state_nxt = S_DATA;
            end
          end
        end else begin
          byte_cnt_nxt = byte_cnt_r;
        end
      end
      S_DATA: begin
        // The counter advances as the write pulse retires, so the pulse sees the old address.
        if (mem_write_enable) begin
          wl_nxt = wl_inc;
          if (wl_inc == len_r) begin
            state_nxt = S_RUN;
            run_nxt   = 1'b1;
          end else begin
            state_nxt = S_DATA;
          end
        end else begin
          wl_nxt = words_loaded;
        end
        if (rx_valid) begin
          asm_nxt      = {asm_r[23:0], rx_data};
          byte_cnt_nxt = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            we_nxt    = 1'b1;
            wdata_nxt = {asm_r[23:0], rx_data};
          end else begin
            we_nxt = 1'b0;
          end
        end else begin
          asm_nxt = asm_r;
        end
      end
      S_RUN: begin
        run_nxt = 1'b1;
      end
      S_ERR: begin
        err_nxt = 1'b1;
        run_nxt = 1'b0;
      end
      default: begin
        state_nxt    = S_LEN;
        byte_cnt_nxt = 2'd0;
      end
    endcase
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time controller for the instruction memory. Receives a program image as a byte stream from the UART receiver, assembles big-endian 32-bit words, and writes them sequentially into instruction memory from address 0. Owns the memory's write port and address mux: during load it drives loader addresses, and after load it hands the address to the fetch stage and releases the CPU.

## Interface
Parameters:
- ADDR_WIDTH, 16, instruction-memory word-address width; also the width of the length header.
- MAX_WORDS, 16000, instruction-memory capacity in words; a larger image is rejected.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte; may be high on consecutive cycles.
- rx_data  in  8  received byte.
- fetch_address  in  ADDR_WIDTH  PC word address from the fetch stage.
- mem_write_enable  out  1  instruction-memory write strobe, registered.
- mem_address  out  ADDR_WIDTH  instruction-memory address.
- mem_write_data  out  32  assembled word, registered.
- cpu_run  out  1  high once the image is fully written; CPU held in stall while low.
- load_error  out  1  sticky; header exceeded MAX_WORDS.
- words_loaded  out  ADDR_WIDTH  count of words written so far.

## Operation
- Image format: 2-byte word count N (high byte first), then 4·N bytes, one word per 4 bytes, most significant byte first.
- States:
  - S_LEN: collects 2 header bytes. On the 2nd byte:
    - N==0 → S_RUN.
    - N>MAX_WORDS → S_ERR.
    - otherwise → S_DATA.
  - S_DATA: shifts bytes into a 32-bit assembly register with a 2-bit byte counter. On the 4th byte it registers a write of the assembled word at address words_loaded. After the write it increments words_loaded. When words_loaded reaches N → S_RUN.
  - S_RUN: terminal until reset. rx_valid is ignored.
  - S_ERR: terminal until reset. load_error=1, cpu_run=0, no writes, rx_valid ignored.
- mem_address = cpu_run ? fetch_address : words_loaded. This is a combinational mux; the address is stable during each write pulse.
- Bytes arriving in the cycle a write pulse is high are accepted normally. The assembly register is independent of the write pulse.
- No write ever targets an address ≥ N. The counter never wraps, because N ≤ MAX_WORDS < 2^ADDR_WIDTH.

## Timing
- Reset (asynchronous, any state, including mid-load or mid-word):
  - Outputs: mem_write_enable=0, mem_write_data=0, cpu_run=0, load_error=0, words_loaded=0, mem_address=0.
  - Internal: state=S_LEN, byte counter=0.
  - The next byte after reset is treated as the header high byte.
- Write latency: 4th byte strobe at cycle t → mem_write_enable=1 for exactly cycle t+1, with address/data valid. words_loaded increments at the end of t+1.
- Last word: its write pulse is at t+1. cpu_run=1 from t+2, and mem_address switches to fetch_address in the same cycle.
- N==0: 2nd header byte at t → cpu_run=1 from t+1.
- Overflow: 2nd header byte at t → load_error=1 from t+1.
- Maximum byte rate: one per cycle, sustained, with no dropped bytes.

## Test plan
- Normal load:
  - Stimulus: header 00 02, then bytes 12 34 56 78 DE AD BE EF, one every 3 cycles.
  - Response: write 0x12345678 @0, then 0xDEADBEEF @1, each pulse one cycle. words_loaded=2. cpu_run rises 2 cycles after byte EF.
- Back-to-back load:
  - Stimulus: header 00 03 and 12 bytes on consecutive cycles.
  - Response: 3 write pulses at addresses 0, 1, 2, spaced 4 cycles apart, with correct data. cpu_run rises 2 cycles after the last byte.
- Empty image:
  - Stimulus: header 00 00.
  - Response: cpu_run=1 one cycle after the 2nd byte. No write pulse. Subsequent bytes produce no writes.
- Oversize image:
  - Stimulus: header 3E 81 (16001), then 8 bytes.
  - Response: load_error=1 one cycle after 0x81. No writes. cpu_run stays 0.
- Reset mid-word:
  - Stimulus: header 00 01 and bytes AA BB, then pulse rst_n low; then stream 00 01 11 22 33 44.
  - Response: all outputs zero during reset. Single write 0x11223344 @0. cpu_run then 1.
- Run mode:
  - Stimulus: after load completes, sweep fetch_address 0..5 and inject rx_valid bytes.
  - Response: mem_address tracks fetch_address in the same cycle. mem_write_enable stays 0.
